// File: rtl/droplator_axi4_burst_responder.sv
// AXI4 burst responder: word-addressed memory endpoint for the DropLator M00_AXI
// master. It accepts INCR write bursts and returns the stored words on INCR read
// bursts. Non-INCR bursts are answered with SLVERR.
module droplator_axi4_burst_responder #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int         IDX_W       = $clog2(MEM_WORDS);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [IDX_W-1:0]      w_idx;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic                  w_err;

    r_state_t              r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic                  r_err;

    logic                  w_fire;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_err;
    logic [IDX_W-1:0]      r_idx_next;
    logic                  unused_addr_bits;

    // Word index is taken modulo the memory depth; byte offset bits are ignored.
    assign aw_idx     = s_axi_awaddr[IDX_W+1:2];
    assign ar_idx     = s_axi_araddr[IDX_W+1:2];
    assign ar_err     = (s_axi_arburst != BURST_INCR);
    assign r_idx_next = r_idx + 1'b1;
    assign w_fire     = s_axi_wvalid && s_axi_wready;
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:IDX_W+2], s_axi_awaddr[1:0],
                                s_axi_araddr[ADDR_WIDTH-1:IDX_W+2], s_axi_araddr[1:0]};

    // Byte-lane memory write for accepted beats of an error-free burst.
    // NOTE: the memory has no reset branch, so its contents survive reset and it
    // can map onto RAM; w_fire is low during reset because wready is held low.
    always_ff @(posedge s_axi_aclk) begin
        if (w_fire && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Write FSM: AW capture, data beats, then a single B response.
    // NOTE: state registers use non-blocking assignments so every branch sees the
    // pre-edge values, matching the hardware flip-flop behaviour.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_id          <= '0;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        w_id          <= s_axi_awid;
                        w_idx         <= aw_idx;
                        w_len         <= s_axi_awlen;
                        w_cnt         <= '0;
                        w_err         <= (s_axi_awburst != BURST_INCR);
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            // A missing wlast on the final beat also flags the burst.
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= (w_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end else if (s_axi_wlast) begin
                            // Early wlast is an error but the burst runs to len.
                            w_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: AR capture, then one registered beat per accepted R handshake.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        r_idx         <= ar_idx;
                        r_len         <= s_axi_arlen;
                        r_cnt         <= '0;
                        r_err         <= ar_err;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= ar_err ? '0 : mem[ar_idx];
                        s_axi_rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_idx       <= r_idx_next;
                            r_cnt       <= r_cnt + 8'd1;
                            s_axi_rdata <= r_err ? '0 : mem[r_idx_next];
                            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_droplator_axi4_burst_responder.sv
// Directed self-checking bench for droplator_axi4_burst_responder. A reference
// memory model predicts read data; expected B and R responses are queued when a
// burst is issued and popped as the DUT presents them.
module tb_droplator_axi4_burst_responder;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int         LIMIT  = 50;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [0:0] id;
    } b_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [0:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [0:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [0:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [64];
    logic [31:0] wbuf [256];
    r_exp_t      r_q[$];
    b_exp_t      b_q[$];

    always #5 clk = ~clk;

    droplator_axi4_burst_responder dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awid   (awid),
        .s_axi_awaddr (awaddr),
        .s_axi_awlen  (awlen),
        .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wlast  (wlast),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bid    (bid),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_arid   (arid),
        .s_axi_araddr (araddr),
        .s_axi_arlen  (arlen),
        .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid    (rid),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rlast  (rlast),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one write burst from wbuf, updates the model, checks the B response.
    task automatic axi_write(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb);
        int         n;
        logic [5:0] idx;
        b_exp_t     e;
        idx    = addr[7:2];
        e.resp = (burst == INCR) ? OKAY : SLVERR;
        e.id   = id;
        b_q.push_back(e);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < LIMIT) begin @(negedge clk); n++; end
        check("aw_handshake", 32'(n < LIMIT), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
            n = 0;
            while (!wready && n < LIMIT) begin @(negedge clk); n++; end
            check($sformatf("w_handshake[%0d]", i), 32'(n < LIMIT), 32'd1);
            @(negedge clk);
            if (burst == INCR) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[idx][8*b +: 8] = wbuf[i][8*b +: 8];
                end
            end
            idx++;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < LIMIT) begin @(negedge clk); n++; end
        check("b_valid", 32'(n < LIMIT), 32'd1);
        e = b_q.pop_front();
        check("bresp", 32'(bresp), 32'(e.resp));
        check("bid", 32'(bid), 32'(e.id));
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_after_b", 32'(bvalid), 32'd0);
    endtask

    // Issues a read burst; stall=1 drives rready as 1,0,0,1,0,0,...
    task automatic axi_read(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit stall);
        int         n;
        int         got;
        int         cyc;
        logic [5:0] idx;
        r_exp_t     e;
        idx = addr[7:2];
        for (int i = 0; i <= int'(len); i++) begin
            e.data = (burst == INCR) ? model_mem[idx] : 32'd0;
            e.resp = (burst == INCR) ? OKAY : SLVERR;
            e.last = (i == int'(len));
            e.id   = id;
            r_q.push_back(e);
            idx++;
        end
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < LIMIT) begin @(negedge clk); n++; end
        check("ar_handshake", 32'(n < LIMIT), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        got = 0;
        cyc = 0;
        while (got <= int'(len) && cyc < 2000) begin
            rready = stall ? (cyc % 3 == 0) : 1'b1;
            if (rvalid) begin
                e = r_q[0];
                check($sformatf("rdata[%0d]", got), rdata, e.data);
                check($sformatf("rresp[%0d]", got), 32'(rresp), 32'(e.resp));
                check($sformatf("rlast[%0d]", got), 32'(rlast), 32'(e.last));
                check($sformatf("rid[%0d]", got), 32'(rid), 32'(e.id));
                if (rready) begin
                    e = r_q.pop_front();
                    got++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", 32'(got), 32'(int'(len) + 1));
        check("rvalid_after_last", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bid", 32'(bid), 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // 8-beat INCR write of 1..8 at 0x0, then read it back.
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
        axi_write(1'b1, 32'h0, 8'd7, INCR, 4'hF);
        axi_read(1'b1, 32'h0, 8'd7, INCR, 1'b0);

        // Partial strobe: lanes 0 and 2 take the new bytes.
        wbuf[0] = 32'h1122_3344;
        axi_write(1'b0, 32'h10, 8'd0, INCR, 4'hF);
        wbuf[0] = 32'hAABB_CCDD;
        axi_write(1'b0, 32'h10, 8'd0, INCR, 4'b0101);
        axi_read(1'b0, 32'h10, 8'd0, INCR, 1'b0);

        // Index wrap: 0xF8 covers words 62, 63, 0, 1.
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        axi_write(1'b1, 32'hF8, 8'd3, INCR, 4'hF);
        axi_read(1'b1, 32'h0, 8'd0, INCR, 1'b0);
        axi_read(1'b0, 32'hFC, 8'd0, INCR, 1'b0);

        // Non-INCR bursts: FIXED write leaves memory alone, WRAP read returns zeros.
        wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'hCAFE_F00D;
        axi_write(1'b0, 32'h0, 8'd1, FIXED, 4'hF);
        axi_read(1'b0, 32'h0, 8'd1, INCR, 1'b0);
        axi_read(1'b1, 32'h0, 8'd2, WRAP, 1'b0);

        // Stalled 4-beat read concurrent with a 4-beat write elsewhere.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5000 + 32'(i);
        fork
            axi_write(1'b1, 32'h40, 8'd3, INCR, 4'hF);
            axi_read(1'b0, 32'h0, 8'd3, INCR, 1'b1);
        join
        axi_read(1'b1, 32'h40, 8'd3, INCR, 1'b0);

        // Reset during beat 3 of an 8-beat write over a preloaded region.
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
        axi_write(1'b0, 32'h80, 8'd7, INCR, 4'hF);
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h200 + 32'(i);
        @(negedge clk);
        awid = 1'b1; awaddr = 32'h80; awlen = 8'd7; awburst = INCR; awvalid = 1'b1;
        n = 0;
        while (!awready && n < LIMIT) begin @(negedge clk); n++; end
        check("abort_aw_handshake", 32'(n < LIMIT), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = wbuf[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            n = 0;
            while (!wready && n < LIMIT) begin @(negedge clk); n++; end
            check($sformatf("abort_w_handshake[%0d]", i), 32'(n < LIMIT), 32'd1);
            @(negedge clk);
            model_mem[32 + i] = wbuf[i];
        end
        wdata = wbuf[2]; wvalid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_rst_awready", 32'(awready), 32'd1);
        check("abort_in_rst_wready", 32'(wready), 32'd0);
        check("abort_in_rst_bvalid", 32'(bvalid), 32'd0);
        @(negedge clk);
        wvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_post_awready", 32'(awready), 32'd1);
        check("abort_post_bvalid", 32'(bvalid), 32'd0);
        check("abort_post_wready", 32'(wready), 32'd0);
        axi_read(1'b0, 32'h80, 8'd7, INCR, 1'b0);

        check("b_queue_empty", 32'(b_q.size()), 32'd0);
        check("r_queue_empty", 32'(r_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
